uart_transmitter: RTL and testbench

//  Serial TX end of the CPU's memory-mapped UART. A store to 0x80000008 hands a byte over a

---
 rtl/uart_transmitter_pkg.sv | 29 ++
 rtl/uart_transmitter_if.sv | 22 ++
 rtl/uart_baud_gen.sv | 46 ++++
 rtl/uart_transmitter.sv | 149 ++++++++++++++
 tb/tb_uart_transmitter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared constants and helpers for the UART transmit path.
//   - FSM state encodings (legacy-compatible logic vectors)
//   - line-level bit values and frame geometry
//   - MMIO addresses software uses to reach the transmitter
//   - frame_of(): builds the 10-bit {stop, data, start} shift image
package uart_transmitter_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Line levels and frame geometry (8N1)
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = DATA_BITS + 2;

    // Memory-mapped register addresses
    localparam logic [31:0] UART_TX_DATA   = 32'h8000_0008;
    localparam logic [31:0] UART_TX_STATUS = 32'h8000_0004;

    // Shift image of a frame; bit 0 goes on the line first.
    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_BITS-1:0] b);
        return {STOP_BIT, b, START_BIT};
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between the CPU store path and the UART transmitter.
//   DataIn       byte to send, meaningful only on an accepted transfer
//   DataInValid  producer has a byte on DataIn
//   DataInReady  transmitter can take a byte this cycle
// A transfer happens on a rising edge where DataInValid && DataInReady.
interface uart_transmitter_if;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;

    modport master (
        output DataIn,
        output DataInValid,
        input  DataInReady
    );

    modport slave (
        input  DataIn,
        input  DataInValid,
        output DataInReady
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmit and receive paths.
// Counts 0..CyclesPerBit-1 and wraps; BitDone is high on the last cycle of
// each period. Clear restarts the count at 0 on the following edge.
// Ports:
//   Clock    core clock
//   Reset    synchronous, active-high
//   Clear    restart the bit period
//   BitDone  combinational, last cycle of the current bit period
module uart_baud_gen #(
    parameter int unsigned CyclesPerBit = 434
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    output logic BitDone
);

    localparam int unsigned TimerW = (CyclesPerBit > 1) ? $clog2(CyclesPerBit) : 1;

    logic [TimerW-1:0] count_q;
    logic [TimerW-1:0] count_d;

    assign BitDone = (count_q == TimerW'(CyclesPerBit - 1));

    // Next count: clear wins, otherwise wrap at the end of the period
    always_comb begin
        count_d = count_q;
        if (Clear) begin
            count_d = '0;
        end else if (BitDone) begin
            count_d = '0;
        end else begin
            count_d = count_q + TimerW'(1);
        end
    end

    // Count register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// Serial transmit end of the memory-mapped UART (8N1).
// Accepts bytes over a ready/valid handshake, keeps one byte in a holding
// register while another shifts, and drives the line from a 10-bit shifter.
// Ports:
//   Clock    core clock, all state updates on the rising edge
//   Reset    synchronous, active-high; aborts any frame in flight
//   tx       byte handshake (slave side)
//   SOut     registered serial line, idles high
//   Busy     registered; shifter active or holding register full
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned ClockFreq = 50_000_000,
    parameter int unsigned BaudRate  = 115_200
) (
    input  logic                 Clock,
    input  logic                 Reset,
    uart_transmitter_if.slave    tx,
    output logic                 SOut,
    output logic                 Busy
);

    localparam int unsigned CyclesPerBit = ClockFreq / BaudRate;

    logic [1:0]            state_q,     state_d;
    logic [FRAME_BITS-1:0] shift_q,     shift_d;
    logic [2:0]            bit_cnt_q,   bit_cnt_d;
    logic [7:0]            hold_q,      hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  busy_q,      busy_d;

    logic                  ready;
    logic                  accept;
    logic                  direct;
    logic                  load;
    logic [7:0]            load_byte;
    logic                  bit_done;

    // Ready never overlaps a full hold, so accept and drain never coincide
    assign ready          = !hold_full_q && !Reset;
    assign tx.DataInReady = ready;

    // Line bit is the bottom of the shifter; idle shifter is all ones
    assign SOut = shift_q[0];
    assign Busy = busy_q;

    uart_baud_gen #(
        .CyclesPerBit (CyclesPerBit)
    ) u_baud_gen (
        .Clock   (Clock),
        .Reset   (Reset),
        .Clear   (load),
        .BitDone (bit_done)
    );

    // Next-state, shifter, bit counter and holding register
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        load_byte   = tx.DataIn;

        accept = tx.DataInValid && ready;
        // A byte goes straight to the shifter when it would otherwise sit
        // idle: nothing running, or the stop bit ending with an empty hold.
        direct = accept && ((state_q == ST_IDLE) ||
                            ((state_q == ST_STOP) && bit_done));

        if (accept && !direct) begin
            hold_d      = tx.DataIn;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (direct) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    shift_d   = {STOP_BIT, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = {STOP_BIT, shift_q[FRAME_BITS-1:1]};
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (hold_full_q) begin
                        // Back-to-back frame from the holding register
                        load        = 1'b1;
                        load_byte   = hold_q;
                        hold_full_d = 1'b0;
                    end else if (direct) begin
                        load = 1'b1;
                    end else begin
                        shift_d = {STOP_BIT, shift_q[FRAME_BITS-1:1]};
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Loading a frame always starts with the start bit and a fresh timer
        if (load) begin
            shift_d   = frame_of(load_byte);
            bit_cnt_d = 3'd0;
            state_d   = ST_START;
        end

        busy_d = (state_d != ST_IDLE) || hold_full_d;
    end

    // State registers; reset discards any frame and the holding byte
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '1;
            bit_cnt_q   <= 3'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a fast instance (10 cycles/bit) for
// framing, back-to-back, toggling-data and reset-abort cases, plus a
// default-parameter instance for bit-period timing.
module tb_uart_transmitter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sout, busy, sout2, busy2;

    always #5 clk = ~clk;

    uart_transmitter_if bus ();
    uart_transmitter_if bus2 ();

    uart_transmitter #(.ClockFreq(1000), .BaudRate(100)) dut (
        .Clock (clk), .Reset (rst), .tx (bus), .SOut (sout), .Busy (busy)
    );

    uart_transmitter dut2 (
        .Clock (clk), .Reset (rst), .tx (bus2), .SOut (sout2), .Busy (busy2)
    );

    int tests = 0;
    int fails = 0;
    bit tog_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks SOut/Busy for cycles first..99 after the accept edge, one tick each
    task automatic check_frame(input logic [7:0] b, input int first, input bit rdy0);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = first; i < 100; i++) begin
            chk("frame_sout", 32'(sout), 32'(f[i / 10]));
            chk("frame_busy", 32'(busy), 32'd1);
            if (rdy0) chk("frame_ready_low", 32'(bus.DataInReady), 32'd0);
            if (tog_en) bus.DataIn = 8'($urandom);
            tick();
        end
    endtask

    // Line decoder: samples mid-bit at 10 cycles/bit, drops frames on reset
    initial begin
        int cnt;
        bit active;
        logic [7:0] byte_v;
        active = 1'b0;
        cnt    = 0;
        byte_v = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (sout === 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                end
            end else begin
                cnt++;
                if ((cnt % 10 == 5) && cnt >= 15 && cnt <= 85)
                    byte_v[(cnt - 15) / 10] = sout;
                if (cnt == 95) begin
                    active = 1'b0;
                    if (sout === 1'b1) got_q.push_back(byte_v);
                end
            end
        end
    end

    initial begin
        int low, hi;
        bus.DataIn       = 8'd0;
        bus.DataInValid  = 1'b0;
        bus2.DataIn      = 8'd0;
        bus2.DataInValid = 1'b0;

        // 1: reset for 3 cycles, then idle
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 32'(bus.DataInReady), 32'd0);
            chk("rst_sout", 32'(sout), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(bus.DataInReady), 32'd1);
        chk("post_rst_sout", 32'(sout), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ready2", 32'(bus2.DataInReady), 32'd1);

        // 2: single byte 0xA5
        bus.DataIn = 8'hA5; bus.DataInValid = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        bus.DataInValid = 1'b0;
        check_frame(8'hA5, 0, 1'b0);
        chk("a5_busy_end", 32'(busy), 32'd0);
        chk("a5_sout_end", 32'(sout), 32'd1);

        // 3: valid held across 0x55, 0x0F, 0xFF
        bus.DataIn = 8'h55; bus.DataInValid = 1'b1;
        exp_q.push_back(8'h55); exp_q.push_back(8'h0F); exp_q.push_back(8'hFF);
        tick();
        chk("b2b_ready_n", 32'(bus.DataInReady), 32'd1);
        bus.DataIn = 8'h0F;
        tick();
        bus.DataIn = 8'hFF;
        check_frame(8'h55, 1, 1'b1);
        chk("b2b_ready_n100", 32'(bus.DataInReady), 32'd1);
        chk("b2b_0f_start", 32'(sout), 32'd0);
        tick();
        bus.DataInValid = 1'b0;
        check_frame(8'h0F, 1, 1'b1);
        check_frame(8'hFF, 0, 1'b0);
        chk("b2b_busy_end", 32'(busy), 32'd0);

        // 4: DataIn toggles while Ready=0; only the Ready=1 value is taken
        bus.DataIn = 8'h11; bus.DataInValid = 1'b1;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'hE7);
        tick();
        bus.DataIn = 8'h22;
        tick();
        tog_en = 1'b1;
        check_frame(8'h11, 1, 1'b1);
        tog_en = 1'b0;
        chk("tog_ready", 32'(bus.DataInReady), 32'd1);
        bus.DataIn = 8'hE7;
        tick();
        bus.DataInValid = 1'b0;
        check_frame(8'h22, 1, 1'b1);
        check_frame(8'hE7, 0, 1'b0);
        chk("tog_busy_end", 32'(busy), 32'd0);

        // 5: reset mid-frame with hold full, then a clean 0x3C
        bus.DataIn = 8'hC3; bus.DataInValid = 1'b1;
        tick();
        bus.DataIn = 8'h96;
        tick();
        bus.DataInValid = 1'b0;
        for (int i = 0; i < 34; i++) tick();
        chk("abort_pre_sout", 32'(sout), 32'd0);
        chk("abort_pre_ready", 32'(bus.DataInReady), 32'd0);
        rst = 1'b1;
        tick();
        chk("abort_sout", 32'(sout), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(bus.DataInReady), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_post_ready", 32'(bus.DataInReady), 32'd1);
        chk("abort_post_busy", 32'(busy), 32'd0);
        chk("abort_post_sout", 32'(sout), 32'd1);
        bus.DataIn = 8'h3C; bus.DataInValid = 1'b1;
        exp_q.push_back(8'h3C);
        tick();
        bus.DataInValid = 1'b0;
        check_frame(8'h3C, 0, 1'b0);
        chk("3c_busy_end", 32'(busy), 32'd0);

        // Scoreboard of decoded line bytes
        for (int i = 0; i < 5; i++) tick();
        chk("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("sb_byte", 32'(got_q[i]), 32'(exp_q[i]));

        // 6: default parameters, 0x00 -> 9*434 low cycles, 434 stop cycles
        bus2.DataIn = 8'h00; bus2.DataInValid = 1'b1;
        chk("def_ready", 32'(bus2.DataInReady), 32'd1);
        tick();
        bus2.DataInValid = 1'b0;
        low = 0;
        while (sout2 === 1'b0 && low < 5000) begin
            low++;
            tick();
        end
        chk("def_low_cycles", 32'(low), 32'd3906);
        hi = 0;
        while (busy2 === 1'b1 && hi < 5000) begin
            if (sout2 !== 1'b1) hi = 5000;
            else hi++;
            tick();
        end
        chk("def_stop_cycles", 32'(hi), 32'd434);
        chk("def_frame_cycles", 32'(low + hi), 32'd4340);
        chk("def_idle_sout", 32'(sout2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
